// File: rtl/jtcps_snd_mix.sv
// Time-multiplexed N-channel stereo mixer: one multiply-accumulate per clock walks the
// snapshotted channels, then the sums are saturated to signed 16 bits with a clip flag.
module jtcps_snd_mix #(
    parameter int CH = 4,
    parameter int GW = 8
) (
    input  logic                 rst,
    input  logic                 clk,
    input  logic                 sample_in,
    input  logic [CH*16-1:0]     ch_in,
    input  logic [CH-1:0]        ch_en,
    input  logic [CH*GW-1:0]     gain,
    input  logic [CH*2-1:0]      route,
    output logic signed [15:0]   left,
    output logic signed [15:0]   right,
    output logic                 clip,
    output logic                 sample_out,
    output logic                 busy,
    output logic [1:0]           dbg_state
);

    localparam int KW = $clog2(CH);
    localparam int AW = 16 + GW + KW;
    localparam int PW = 17 + GW;
    localparam logic [KW-1:0]        K_LAST = KW'(CH - 1);
    localparam logic signed [AW-1:0] MAX_V  = AW'(32767);
    localparam logic signed [AW-1:0] MIN_V  = AW'(-32768);

    typedef enum logic [1:0] {IDLE = 2'd0, MAC = 2'd1, SAT = 2'd2} state_t;

    state_t                state_q, state_d;
    logic [KW-1:0]         k_q, k_d;
    logic                  pending_q, pending_d;
    logic [CH*16-1:0]      snap_ch_q, snap_ch_d;
    logic [CH-1:0]         snap_en_q, snap_en_d;
    logic [CH*GW-1:0]      snap_gain_q, snap_gain_d;
    logic [CH*2-1:0]       snap_route_q, snap_route_d;
    logic signed [AW-1:0]  acc_l_q, acc_l_d, acc_r_q, acc_r_d;
    logic signed [15:0]    left_q, left_d, right_q, right_d;
    logic                  clip_q, clip_d, so_q, so_d, busy_q, busy_d;
    logic                  start;

    logic signed [15:0]    cur_ch;
    logic [GW-1:0]         cur_gain;
    logic [1:0]            cur_route;
    logic                  cur_en;
    logic signed [PW-1:0]  prod, term;
    logic signed [AW-1:0]  term_ext;
    logic [16:0]           sat_l, sat_r;

    // Clamp to the 16-bit range; bit 16 reports that clamping happened.
    function automatic logic [16:0] sat16(input logic signed [AW-1:0] a);
        if (a > MAX_V)      sat16 = {1'b1, 16'h7FFF};
        else if (a < MIN_V) sat16 = {1'b1, 16'h8000};
        else                sat16 = {1'b0, a[15:0]};
    endfunction

    assign cur_ch    = $signed(snap_ch_q[16*k_q +: 16]);
    assign cur_gain  = snap_gain_q[GW*k_q +: GW];
    assign cur_route = snap_route_q[2*k_q +: 2];
    assign cur_en    = snap_en_q[k_q];
    assign prod      = cur_ch * $signed({1'b0, cur_gain});
    assign term      = prod >>> 4;
    assign term_ext  = AW'(term);
    assign sat_l     = sat16(acc_l_q);
    assign sat_r     = sat16(acc_r_q);

    always_comb begin
        state_d      = state_q;
        k_d          = k_q;
        pending_d    = pending_q;
        snap_ch_d    = snap_ch_q;
        snap_en_d    = snap_en_q;
        snap_gain_d  = snap_gain_q;
        snap_route_d = snap_route_q;
        acc_l_d      = acc_l_q;
        acc_r_d      = acc_r_q;
        left_d       = left_q;
        right_d      = right_q;
        clip_d       = clip_q;
        so_d         = 1'b0;
        busy_d       = busy_q;
        start        = 1'b0;
        case (state_q)
            IDLE: start = sample_in;
            MAC: begin
                // Only one strobe can be queued; later ones are silently dropped.
                if (sample_in) pending_d = 1'b1;
                if (cur_en && cur_route[0]) acc_l_d = acc_l_q + term_ext;
                if (cur_en && cur_route[1]) acc_r_d = acc_r_q + term_ext;
                if (k_q == K_LAST) state_d = SAT;
                else               k_d     = k_q + 1'b1;
            end
            SAT: begin
                left_d  = $signed(sat_l[15:0]);
                right_d = $signed(sat_r[15:0]);
                clip_d  = sat_l[16] | sat_r[16];
                so_d    = 1'b1;
                if (pending_q || sample_in) begin
                    pending_d = 1'b0;
                    start     = 1'b1;
                end else begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
        if (start) begin
            snap_ch_d    = ch_in;
            snap_en_d    = ch_en;
            snap_gain_d  = gain;
            snap_route_d = route;
            acc_l_d      = '0;
            acc_r_d      = '0;
            k_d          = '0;
            state_d      = MAC;
            busy_d       = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            k_q          <= '0;
            pending_q    <= 1'b0;
            snap_ch_q    <= '0;
            snap_en_q    <= '0;
            snap_gain_q  <= '0;
            snap_route_q <= '0;
            acc_l_q      <= '0;
            acc_r_q      <= '0;
            left_q       <= '0;
            right_q      <= '0;
            clip_q       <= 1'b0;
            so_q         <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            k_q          <= k_d;
            pending_q    <= pending_d;
            snap_ch_q    <= snap_ch_d;
            snap_en_q    <= snap_en_d;
            snap_gain_q  <= snap_gain_d;
            snap_route_q <= snap_route_d;
            acc_l_q      <= acc_l_d;
            acc_r_q      <= acc_r_d;
            left_q       <= left_d;
            right_q      <= right_d;
            clip_q       <= clip_d;
            so_q         <= so_d;
            busy_q       <= busy_d;
        end
    end

    assign left       = left_q;
    assign right      = right_q;
    assign clip       = clip_q;
    assign sample_out = so_q;
    assign busy       = busy_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_jtcps_snd_mix.sv
// Bench for jtcps_snd_mix: directed literal cases plus randomized strobes checked every
// cycle against a transaction-level model of the mixer.
module tb_jtcps_snd_mix;
    localparam int CH = 4;
    localparam int GW = 8;

    logic                clk = 1'b0;
    logic                rst;
    logic                sample_in;
    logic [CH*16-1:0]    ch_in;
    logic [CH-1:0]       ch_en;
    logic [CH*GW-1:0]    gain;
    logic [CH*2-1:0]     route;
    logic signed [15:0]  left, right;
    logic                clip, sample_out, busy;
    logic [1:0]          dbg_state;

    logic signed [15:0]  ch_a[CH];
    logic [GW-1:0]       gain_a[CH];
    logic [1:0]          route_a[CH];

    int total = 0;
    int bad   = 0;

    jtcps_snd_mix #(.CH(CH), .GW(GW)) dut (
        .rst(rst), .clk(clk), .sample_in(sample_in), .ch_in(ch_in), .ch_en(ch_en),
        .gain(gain), .route(route), .left(left), .right(right), .clip(clip),
        .sample_out(sample_out), .busy(busy), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    always_comb begin
        ch_in = '0;
        gain  = '0;
        route = '0;
        for (int k = 0; k < CH; k++) begin
            ch_in[k*16 +: 16] = ch_a[k];
            gain[k*GW +: GW]  = gain_a[k];
            route[k*2 +: 2]   = route_a[k];
        end
    end

    // Reference mix of the current bench inputs: exact floor(sample*gain/16) per channel,
    // summed with unbounded integers, then clamped. Result is {left, right, clip}.
    function automatic logic [32:0] mix();
        longint al, ar, p, t;
        logic [15:0] l, r;
        logic cl;
        al = 0;
        ar = 0;
        for (int k = 0; k < CH; k++) begin
            if (ch_en[k]) begin
                p = longint'(ch_a[k]) * longint'(gain_a[k]);
                if (p >= 0) t = p / 16;
                else        t = -((-p + 15) / 16);
                if (route_a[k][0]) al = al + t;
                if (route_a[k][1]) ar = ar + t;
            end
        end
        cl = (al > 32767) || (al < -32768) || (ar > 32767) || (ar < -32768);
        l = (al > 32767) ? 16'h7FFF : (al < -32768) ? 16'h8000 : al[15:0];
        r = (ar > 32767) ? 16'h7FFF : (ar < -32768) ? 16'h8000 : ar[15:0];
        return {l, r, cl};
    endfunction

    // Transaction model: a mix accepted at edge t delivers its result at edge t+CH+1;
    // one extra strobe during a mix (including the delivery edge) restarts immediately.
    logic        m_active, m_pending, m_so, m_clip;
    int          m_age;
    logic [32:0] m_res;
    logic [15:0] m_left, m_right;
    logic [32:0] exp_q[$];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_active  <= 1'b0;
            m_pending <= 1'b0;
            m_age     <= 0;
            m_so      <= 1'b0;
            m_left    <= '0;
            m_right   <= '0;
            m_clip    <= 1'b0;
            m_res     <= '0;
            exp_q.delete();
        end else begin
            m_so <= 1'b0;
            if (m_active && m_age == CH) begin
                m_left  <= m_res[32:17];
                m_right <= m_res[16:1];
                m_clip  <= m_res[0];
                m_so    <= 1'b1;
                exp_q.push_back(m_res);
                if (m_pending || sample_in) begin
                    m_res     <= mix();
                    m_age     <= 0;
                    m_pending <= 1'b0;
                end else begin
                    m_active <= 1'b0;
                end
            end else if (m_active) begin
                m_age <= m_age + 1;
                if (sample_in) m_pending <= 1'b1;
            end else if (sample_in) begin
                m_active <= 1'b1;
                m_age    <= 0;
                m_res    <= mix();
            end
        end
    end

    always @(negedge clk) begin
        logic [32:0] e;
        total++;
        if ({left, right, clip, sample_out, busy} !== {m_left, m_right, m_clip, m_so, m_active}) begin
            bad++;
            $display("FAIL cycle_check t=%0t got l=%h r=%h clip=%b so=%b busy=%b want l=%h r=%h clip=%b so=%b busy=%b",
                     $time, left, right, clip, sample_out, busy, m_left, m_right, m_clip, m_so, m_active);
        end
        if (sample_out) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL scoreboard t=%0t got sample_out with l=%h r=%h, want no pulse", $time, left, right);
            end else begin
                e = exp_q.pop_front();
                if ({left, right, clip} !== e) begin
                    bad++;
                    $display("FAIL scoreboard t=%0t got l=%h r=%h clip=%b want l=%h r=%h clip=%b",
                             $time, left, right, clip, e[32:17], e[16:1], e[0]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    task automatic strobe();
        sample_in = 1'b1;
        tick();
        sample_in = 1'b0;
    endtask

    task automatic wait_out(output int n);
        n = 0;
        while (!sample_out && n < 50) begin
            tick();
            n++;
        end
    endtask

    task automatic set_ch(input int k, input logic [15:0] s, input logic [GW-1:0] g, input logic [1:0] r);
        ch_a[k]    = s;
        gain_a[k]  = g;
        route_a[k] = r;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, p1, p2, pulses;
        logic [15:0] v1, v2;

        rst = 1'b1;
        sample_in = 1'b0;
        ch_en = '0;
        for (int k = 0; k < CH; k++) set_ch(k, 16'h0, 8'h0, 2'b00);
        tick();
        tick();
        check("reset_left", left, 16'h0);
        check("reset_right", right, 16'h0);
        check("reset_flags", {13'd0, clip, sample_out, busy}, 16'h0);
        rst = 1'b0;
        tick();

        // Unity pass-through on channel 0 with noise elsewhere disabled.
        for (int k = 1; k < CH; k++) set_ch(k, 16'($urandom), 8'($urandom), 2'($urandom));
        set_ch(0, 16'h1234, 8'h10, 2'b11);
        ch_en = 4'b0001;
        strobe();
        wait_out(n);
        check("unity_latency", 16'(n), 16'd5);
        check("unity_left", left, 16'h1234);
        check("unity_right", right, 16'h1234);
        check("unity_clip", {15'd0, clip}, 16'h0);
        tick();

        // Positive and negative saturation.
        for (int k = 0; k < CH; k++) set_ch(k, 16'h7000, 8'h10, 2'b11);
        ch_en = 4'b1111;
        strobe();
        wait_out(n);
        check("satpos_left", left, 16'h7FFF);
        check("satpos_right", right, 16'h7FFF);
        check("satpos_clip", {15'd0, clip}, 16'h1);
        tick();
        for (int k = 0; k < CH; k++) set_ch(k, 16'h9000, 8'h10, 2'b11);
        strobe();
        wait_out(n);
        check("satneg_left", left, 16'h8000);
        check("satneg_right", right, 16'h8000);
        check("satneg_clip", {15'd0, clip}, 16'h1);
        tick();

        // Gain, floor toward -inf, per-side routing, disabled channel.
        set_ch(0, 16'hFFFD, 8'h08, 2'b01);
        set_ch(1, 16'h0100, 8'h20, 2'b10);
        set_ch(2, 16'h7FFF, 8'h10, 2'b11);
        set_ch(3, 16'h4000, 8'h10, 2'b11);
        ch_en = 4'b0011;
        strobe();
        wait_out(n);
        check("floor_left", left, 16'hFFFE);
        check("route_right", right, 16'h0200);
        check("floor_clip", {15'd0, clip}, 16'h0);
        tick();

        // Back-to-back: second strobe queues, third is dropped.
        set_ch(0, 16'h0010, 8'h10, 2'b11);
        ch_en = 4'b0001;
        strobe();
        tick();
        ch_a[0] = 16'h0020;
        sample_in = 1'b1;
        tick();
        tick();
        sample_in = 1'b0;
        pulses = 0;
        p1 = 0; p2 = 0; v1 = '0; v2 = '0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (sample_out) begin
                pulses++;
                if (pulses == 1) begin p1 = i; v1 = left; end
                if (pulses == 2) begin p2 = i; v2 = left; end
            end
        end
        check("b2b_pulses", 16'(pulses), 16'd2);
        check("b2b_first", v1, 16'h0010);
        check("b2b_second", v2, 16'h0020);
        check("b2b_spacing", 16'(p2 - p1), 16'd5);

        // Reset while the third channel is about to accumulate.
        set_ch(0, 16'h0500, 8'h10, 2'b11);
        strobe();
        tick();
        tick();
        rst = 1'b1;
        #1;
        check("midrst_left", left, 16'h0);
        check("midrst_busy", {15'd0, busy}, 16'h0);
        tick();
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (sample_out) pulses++;
        end
        check("midrst_no_pulse", 16'(pulses), 16'd0);
        strobe();
        wait_out(n);
        check("postrst_latency", 16'(n), 16'd5);
        check("postrst_left", left, 16'h0500);

        // Outputs hold with no strobes.
        pulses = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (sample_out) pulses++;
        end
        check("hold_pulses", 16'(pulses), 16'd0);
        check("hold_left", left, 16'h0500);
        check("hold_right", right, 16'h0500);
        check("hold_clip", {15'd0, clip}, 16'h0);

        // Randomized traffic with occasional resets; inputs churn during mixes.
        for (int i = 0; i < 1500; i++) begin
            rst = ($urandom_range(0, 299) == 0);
            sample_in = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 1) == 0) begin
                for (int k = 0; k < CH; k++)
                    set_ch(k, 16'($urandom), ($urandom_range(0, 3) == 0) ? 8'h10 : 8'($urandom),
                           2'($urandom));
                ch_en = 4'($urandom);
            end
            tick();
        end
        rst = 1'b0;
        sample_in = 1'b0;
        repeat (20) tick();
        check("drain_queue", 16'(exp_q.size()), 16'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/jtcps_snd_mix.md
# jtcps_snd_mix

Parametrised, time-multiplexed stereo mixer for the CPS sound subsystems. It replaces the fixed two-source FM+ADPCM sum with N channels, each with its own gain, routing and enable. It sits between the sound chips (FM, ADPCM, QSound-style PCM voices) and the board audio output. A single multiply-accumulate datapath walks the channels once per sample strobe and produces saturated 16-bit left/right outputs with a clip flag.

## Interface
Parameters:
- CH, 4: number of input channels, 2..8.
- GW, 8: gain width, unsigned Q(GW-4).4; 16 (0x10) = unity.

Ports:
- rst  input  1  asynchronous reset, active-high
- clk  input  1  system clock (48 MHz)
- sample_in  input  1  one-clk strobe; starts a mix of the current inputs
- ch_in  input  CH*16  packed signed channel samples, channel k at [16k+15:16k]
- ch_en  input  CH  per-channel enable; 0 means the channel contributes 0
- gain  input  CH*GW  packed unsigned gains
- route  input  CH*2  per-channel routing: bit0 feeds left, bit1 feeds right
- left  output  16  signed saturated left mix
- right  output  16  signed saturated right mix
- clip  output  1  high if either side saturated in the last mix
- sample_out  output  1  one-clk strobe when left/right/clip update
- busy  output  1  mix in progress

## Operation
- Reset: left=0, right=0, clip=0, sample_out=0, busy=0, pending=0, FSM in IDLE, accumulators 0.
- FSM states: IDLE, MAC, SAT.
- IDLE: when sample_in=1, snapshot ch_in, ch_en, gain and route into internal registers, clear both accumulators, set k=0, go to MAC, busy=1.
- MAC: one channel per clk. prod = ch_in[k] * {0,gain[k]}, a 16+GW+1-bit signed value. term = prod >>> 4, arithmetic, so it floors toward −inf. If ch_en[k] then acc_l += term when route[k][0], and acc_r += term when route[k][1]. After k=CH-1, go to SAT.
- Accumulator width is 16+GW+clog2(CH) bits, and it never wraps.
- SAT: clamp each accumulator to [-32768, 32767] and register the results into left and right. clip = (either side clamped). Pulse sample_out. Then:
  - if pending=1, clear pending and restart exactly as from IDLE, snapshotting the inputs present at this edge;
  - otherwise go to IDLE with busy=0.
- sample_in while busy: set pending=1. A strobe arriving while pending is already 1 is dropped and does not raise any flag.
- sample_in coinciding with the SAT cycle counts as pending, so it is handled by the restart.
- Inputs may change freely during MAC; only the snapshot is used.
- left, right and clip hold their values between sample_out pulses.
- Reset mid-mix: all state returns to reset values immediately, and no sample_out is issued.

## Timing
- sample_in sampled high at edge t: the snapshot is taken at edge t and busy rises after edge t.
- Channel k accumulates at edge t+1+k.
- The SAT result is registered at edge t+CH+1. sample_out is high for the cycle after edge t+CH+1, and left/right are valid from that same edge.
- Latency is CH+1 clks from strobe to output. busy falls at edge t+CH+1 unless pending.
- Minimum strobe spacing without queuing is CH+2 clks.

## Test plan
- Unity pass-through (CH=4): ch0=0x1234, gain0=0x10, route0=3, en=0001, others any → left=right=0x1234, clip=0, sample_out exactly 5 clks after the strobe.
- Saturation: all channels 0x7000, gain 0x10, route 3, en=1111 → left=right=0x7FFF, clip=1. Same test with 0x9000 → 0x8000, clip=1.
- Gain, floor and routing: ch0=-3, gain0=0x08, route0=1 (left only); ch1=0x0100, gain1=0x20, route1=2 (right only) → left=-2 (floor of -1.5), right=0x0200. A disabled ch2=0x7FFF contributes 0.
- Back-to-back strobes: second strobe 2 clks after the first with ch0 changed 0x0010→0x0020 → two sample_out pulses, 0x0010 then 0x0020, 5 clks apart. A third strobe while pending is dropped, so only two pulses occur.
- Reset mid-MAC: assert rst at k=2 → outputs 0, busy 0, no sample_out. The next strobe after release mixes normally.
- Hold: no strobes for 100 clks after a mix → left/right/clip unchanged, sample_out stays 0.
